// File: rtl/tetris_input_ctrl_pkg.sv
// Shared types and default timing for the Tetris player-input front end.
package tetris_input_pkg;

  typedef enum logic [1:0] {
    ZONE_CENTER = 2'd0,
    ZONE_LEFT   = 2'd1,
    ZONE_RIGHT  = 2'd2
  } joy_zone_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DAS    = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_ADC_W      = 12;
  localparam int DEF_LEFT_THR   = 1300;
  localparam int DEF_RIGHT_THR  = 2000;
  localparam int DEF_HYST       = 100;
  localparam int DEF_NBTN       = 2;
  localparam int DEF_DEB_CYCLES = 500000;
  localparam int DEF_DAS_CYCLES = 10000000;
  localparam int DEF_ARR_CYCLES = 2500000;

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Player-input bundle: joystick samples and buttons in, move strobes, zone, LEDs out.
interface tetris_input_ctrl_if #(
  parameter int ADC_W = 12,
  parameter int NBTN  = 2
);
  logic              enable;
  logic [ADC_W-1:0]  adc_value;
  logic              adc_valid;
  logic [NBTN-1:0]   btn_raw;
  logic              move_left;
  logic              move_right;
  logic [1:0]        joy_zone;
  logic [NBTN-1:0]   btn_level;
  logic [NBTN-1:0]   btn_press;
  logic              led_red;
  logic              led_green;

  modport slave (
    input  enable, adc_value, adc_valid, btn_raw,
    output move_left, move_right, joy_zone, btn_level, btn_press, led_red, led_green
  );

  modport master (
    output enable, adc_value, adc_valid, btn_raw,
    input  move_left, move_right, joy_zone, btn_level, btn_press, led_red, led_green
  );
endinterface

// File: rtl/tetris_input_ctrl_debounce.sv
// One pushbutton channel: 2-FF synchronizer, stability counter, rising-edge press pulse.
module input_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          prs_q, prs_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts the stability window.
  always_comb begin
    lvl_d = lvl_q;
    prs_d = 1'b0;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = ~lvl_q;
        prs_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      prs_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign press_o = prs_q;
endmodule

// File: rtl/tetris_input_ctrl.sv
// Joystick zone classifier with hysteresis, DAS/ARR auto-repeat FSM, and N debounced buttons.
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int ADC_W      = DEF_ADC_W,
  parameter int LEFT_THR   = DEF_LEFT_THR,
  parameter int RIGHT_THR  = DEF_RIGHT_THR,
  parameter int HYST       = DEF_HYST,
  parameter int NBTN       = DEF_NBTN,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DAS_CYCLES = DEF_DAS_CYCLES,
  parameter int ARR_CYCLES = DEF_ARR_CYCLES
) (
  input  logic clk,
  input  logic reset,
  tetris_input_ctrl_if.slave io
);
  localparam int RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  localparam logic [ADC_W-1:0] L_ENTER = ADC_W'(LEFT_THR);
  localparam logic [ADC_W-1:0] L_EXIT  = ADC_W'(LEFT_THR + HYST);
  localparam logic [ADC_W-1:0] R_ENTER = ADC_W'(RIGHT_THR);
  localparam logic [ADC_W-1:0] R_EXIT  = ADC_W'(RIGHT_THR - HYST);

  if (!(LEFT_THR + HYST < RIGHT_THR - HYST)) begin : g_bad_thr
    $error("tetris_input_ctrl: hysteresis bands overlap");
  end
  if (DEB_CYCLES < 1 || DAS_CYCLES < 1 || ARR_CYCLES < 1) begin : g_bad_cyc
    $error("tetris_input_ctrl: cycle parameters must be >= 1");
  end

  joy_zone_e  zone_q, zone_d;
  joy_zone_e  dir_q, dir_d;
  rpt_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ml_q, ml_d, mr_q, mr_d;
  logic fire;

  // Zone only moves on fresh samples; exits use the widened band, entries the raw threshold.
  always_comb begin
    zone_d = zone_q;
    if (io.adc_valid) begin
      case (zone_q)
        ZONE_CENTER: begin
          if (io.adc_value > R_ENTER)      zone_d = ZONE_RIGHT;
          else if (io.adc_value < L_ENTER) zone_d = ZONE_LEFT;
        end
        ZONE_RIGHT: begin
          if (io.adc_value < L_ENTER)      zone_d = ZONE_LEFT;
          else if (io.adc_value < R_EXIT)  zone_d = ZONE_CENTER;
        end
        ZONE_LEFT: begin
          if (io.adc_value > R_ENTER)      zone_d = ZONE_RIGHT;
          else if (io.adc_value >= L_EXIT) zone_d = ZONE_CENTER;
        end
        default: zone_d = ZONE_CENTER;
      endcase
    end
  end

  // Fresh entry and reversal share one path: pulse now, restart the DAS window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fire    = 1'b0;
    if (!io.enable || zone_q == ZONE_CENTER) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else if (state_q == RPT_IDLE || zone_q != dir_q) begin
      state_d = RPT_DAS;
      cnt_d   = '0;
      dir_d   = zone_q;
      fire    = 1'b1;
    end else begin
      case (state_q)
        RPT_DAS: begin
          if (cnt_q == DAS_LAST) begin
            state_d = RPT_REPEAT;
            cnt_d   = '0;
            fire    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == ARR_LAST) begin
            cnt_d = '0;
            fire  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    ml_d = fire && (dir_d == ZONE_LEFT);
    mr_d = fire && (dir_d == ZONE_RIGHT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zone_q  <= ZONE_CENTER;
      dir_q   <= ZONE_CENTER;
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      ml_q    <= 1'b0;
      mr_q    <= 1'b0;
    end else begin
      zone_q  <= zone_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ml_q    <= ml_d;
      mr_q    <= mr_d;
    end
  end

  logic [NBTN-1:0] btn_level, btn_press;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (io.btn_raw[g]),
      .level_o (btn_level[g]),
      .press_o (btn_press[g])
    );
  end

  assign io.move_left  = ml_q;
  assign io.move_right = mr_q;
  assign io.joy_zone   = zone_q;
  assign io.led_red    = (zone_q == ZONE_RIGHT);
  assign io.led_green  = (zone_q == ZONE_LEFT);
  assign io.btn_level  = btn_level;
  assign io.btn_press  = btn_press;
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Randomized + directed bench for tetris_input_ctrl against a timing-rule reference model.
module tb_tetris_input_ctrl;
  localparam int ADC_W = 12;
  localparam int NBTN  = 2;
  localparam int DEB   = 4;
  localparam int DAS   = 10;
  localparam int ARR   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tetris_input_ctrl_if #(.ADC_W(ADC_W), .NBTN(NBTN)) bus();

  tetris_input_ctrl #(
    .ADC_W(ADC_W), .NBTN(NBTN),
    .DEB_CYCLES(DEB), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model: zone as int (0 C, 1 L, 2 R); repeat timing as "cycles held since entry".
  int m_zone, m_dir, m_held;
  bit m_eng, m_ml, m_mr;
  bit [NBTN-1:0] m_s1, m_s2, m_lvl, m_prs;
  int m_run [NBTN];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_zone = 0; m_dir = 0; m_held = 0; m_eng = 0; m_ml = 0; m_mr = 0;
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0;
    for (int i = 0; i < NBTN; i++) m_run[i] = 0;
  endfunction

  function automatic void model_edge();
    int v, nz;
    bit old_s2;
    if (reset) begin
      model_reset();
      return;
    end
    v  = int'(bus.adc_value);
    nz = m_zone;
    if (bus.adc_valid) begin
      if (m_zone == 0)      nz = (v > 2000) ? 2 : (v < 1300) ? 1 : 0;
      else if (m_zone == 2) nz = (v < 1300) ? 1 : (v < 1900) ? 0 : 2;
      else                  nz = (v > 2000) ? 2 : (v >= 1400) ? 0 : 1;
    end
    m_ml = 0; m_mr = 0;
    if (!bus.enable || m_zone == 0) m_eng = 0;
    else if (!m_eng || m_zone != m_dir) begin
      m_eng = 1; m_dir = m_zone; m_held = 0;
      m_ml = (m_dir == 1); m_mr = (m_dir == 2);
    end else begin
      m_held++;
      if (m_held >= DAS && (m_held - DAS) % ARR == 0) begin
        m_ml = (m_dir == 1); m_mr = (m_dir == 2);
      end
    end
    m_zone = nz;
    for (int i = 0; i < NBTN; i++) begin
      old_s2  = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = bus.btn_raw[i];
      m_prs[i] = 1'b0;
      if (old_s2 != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          m_prs[i] = m_lvl[i];
        end
      end else m_run[i] = 0;
    end
  endfunction

  task automatic compare_all();
    check("move_left",  bus.move_left,  m_ml);
    check("move_right", bus.move_right, m_mr);
    check("joy_zone",   bus.joy_zone,   m_zone);
    check("led_red",    bus.led_red,    m_zone == 2);
    check("led_green",  bus.led_green,  m_zone == 1);
    check("btn_level",  bus.btn_level,  m_lvl);
    check("btn_press",  bus.btn_press,  m_prs);
    check("move_excl",  bus.move_left & bus.move_right, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input int v);
    bus.adc_value = ADC_W'(v);
    bus.adc_valid = 1'b1;
    step();
    bus.adc_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    reset = 1'b0;
  endtask

  int cnt;

  initial begin
    bus.enable = 1'b1; bus.adc_value = '0; bus.adc_valid = 1'b0; bus.btn_raw = '0;
    model_reset();
    #2;
    compare_all();
    check("rst_zone", bus.joy_zone, 0);
    step();
    reset = 1'b0;
    step();

    // Right entry, DAS then ARR repeats, band hold, exit
    send(2100);
    check("t1_zone", bus.joy_zone, 2);
    check("t1_red", bus.led_red, 1);
    cnt = 0;
    for (int k = 2; k <= 18; k++) begin
      step();
      if (bus.move_right) cnt++;
      if (k == 2 || k == 12 || k == 15 || k == 18) check("t1_pulse", bus.move_right, 1);
    end
    check("t1_npulse", cnt, 4);
    send(1950);
    check("t1_band", bus.joy_zone, 2);
    send(1850);
    check("t1_center", bus.joy_zone, 0);
    repeat (15) step();

    // Left hysteresis
    send(1250);
    check("t2_zone", bus.joy_zone, 1);
    step();
    check("t2_pulse", bus.move_left, 1);
    send(1350);
    check("t2_band", bus.joy_zone, 1);
    send(1400);
    check("t2_center", bus.joy_zone, 0);
    repeat (4) step();

    // Reversal out of REPEAT
    send(2100);
    repeat (13) step();
    send(1000);
    check("t3_zone", bus.joy_zone, 1);
    step();
    check("t3_left", bus.move_left, 1);
    check("t3_noright", bus.move_right, 0);
    repeat (9) step();
    step();
    check("t3_das", bus.move_left, 1);

    // Enable gating
    bus.enable = 1'b0;
    send(2100);
    check("t4_red", bus.led_red, 1);
    repeat (5) begin
      step();
      check("t4_quiet", bus.move_right, 0);
    end
    bus.enable = 1'b1;
    step();
    check("t4_entry", bus.move_right, 1);
    send(1600);
    repeat (3) step();

    // Debounce: glitch, press, release
    bus.btn_raw = 2'b01;
    repeat (3) step();
    bus.btn_raw = 2'b00;
    repeat (8) step();
    check("t5_glitch", bus.btn_level[0], 0);
    bus.btn_raw = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 5) check("t5_early", bus.btn_level[0], 0);
      if (k == 6) begin
        check("t5_level", bus.btn_level[0], 1);
        check("t5_press", bus.btn_press[0], 1);
      end
      if (k == 7) check("t5_press1", bus.btn_press[0], 0);
    end
    bus.btn_raw = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) check("t5_hold", bus.btn_level[0], 1);
      if (k == 6) begin
        check("t5_fall", bus.btn_level[0], 0);
        check("t5_nopress", bus.btn_press[0], 0);
      end
    end

    // Reset mid-DAS and mid-debounce
    send(2100);
    repeat (3) step();
    bus.btn_raw = 2'b01;
    repeat (2) step();
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_zone", bus.joy_zone, 0);
    check("t6_red", bus.led_red, 0);
    compare_all();
    bus.adc_value = 12'd2100;
    bus.adc_valid = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("t6_zone2", bus.joy_zone, 2);
    check("t6_early", bus.move_right, 0);
    step();
    check("t6_entry", bus.move_right, 1);
    bus.adc_valid = 1'b0;
    bus.btn_raw = 2'b00;

    // Randomized phase with sticky joystick values and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.adc_value = ADC_W'($urandom_range(0, 4095));
          1: bus.adc_value = ADC_W'($urandom_range(1250, 1450));
          2: bus.adc_value = ADC_W'($urandom_range(1850, 2050));
          default: bus.adc_value = ADC_W'($urandom_range(2050, 4095));
        endcase
      end
      bus.adc_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 79) == 0) bus.enable = ~bus.enable;
      for (int i = 0; i < NBTN; i++)
        if ($urandom_range(0, 7) == 0) bus.btn_raw[i] = ~bus.btn_raw[i];
      if ($urandom_range(0, 699) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
